ram_reader: RTL and testbench

RAM_READER -- requirements
Module: ram_reader

---
 rtl/ram_reader.sv | 195 +++++++++++++++++++
 tb/tb_ram_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_reader.sv
// ram_reader -- streams a burst of words out of a synchronous-read RAM.
//
// A burst is requested with a one-cycle start pulse carrying a base address
// and a word count. The block walks the RAM addresses base, base+1, ...
// (wrapping modulo the RAM depth), captures each returned word into a
// two-entry output FIFO and presents the words in address order on a
// valid/ready stream. A one-cycle done pulse follows the final transfer.
// The block only reads; it never drives the RAM's load port.
//
// Optional feature: define RAM_READER_LAST_EN to add the out_last port,
// which flags the final word of each burst alongside out_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      one-cycle burst request, sampled only when idle
//   base       first RAM address of the burst (sampled with start)
//   count      number of words to read, 0..2^awidth (sampled with start)
//   ram_addr   address to the RAM's addr port
//   ram_q      RAM read data, valid one cycle after ram_addr is presented
//   out_valid  out_data holds a word
//   out_ready  consumer accepts the word
//   out_data   word read from RAM
//   busy       burst in progress
//   done       one-cycle pulse at the end of a burst
//   out_last   (RAM_READER_LAST_EN only) final word of the burst

`ifndef DATA_LEN
`define DATA_LEN 1
`endif

module ram_reader #(
  parameter int dwidth = 288*`DATA_LEN,
  parameter int awidth = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [awidth-1:0] base,
  input  logic [awidth:0]   count,
  output logic [awidth-1:0] ram_addr,
  input  logic [dwidth-1:0] ram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [dwidth-1:0] out_data,
  output logic              busy,
  output logic              done
`ifdef RAM_READER_LAST_EN
  ,
  output logic              out_last
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [awidth:0]   cnt_one  = (awidth+1)'(1);
  localparam logic [awidth-1:0] addr_one = awidth'(1);

  state_t            state_q, state_d;
  logic [awidth-1:0] addr_q, addr_d;
  logic              addr_valid_q, addr_valid_d;
  logic [awidth:0]   issue_left_q, issue_left_d;
  logic [awidth:0]   words_left_q, words_left_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [dwidth-1:0] fifo_q [2];
  logic [dwidth-1:0] fifo_d [2];
  logic              done_q, done_d;

  logic              xfer;
  logic              issue;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    issue_left_d = issue_left_q;
    words_left_d = words_left_q;
    occ_d        = occ_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_d       = fifo_q;
    done_d       = 1'b0;

    xfer = (occ_q != 2'd0) && out_ready;

    // A read may be issued when the FIFO has room for everything already
    // requested, or when a word leaves the FIFO in this same cycle. With a
    // single in-flight slot this keeps occupancy at or below two.
    issue = (state_q == RUN) && addr_valid_q &&
            (((occ_q + {1'b0, inflight_q}) < 2'd2) || xfer);

    // The word requested this cycle appears on ram_q next cycle.
    inflight_d = issue;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d      = RUN;
            addr_d       = base;
            // The first RUN cycle only loads the address; reads start on
            // the following cycle, once ram_addr has been stable a cycle.
            addr_valid_d = 1'b0;
            issue_left_d = count;
            words_left_d = count;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        addr_valid_d = 1'b1;
        if (issue) begin
          addr_d       = addr_q + addr_one;  // wraps naturally at 2^awidth
          issue_left_d = issue_left_q - cnt_one;
          if (issue_left_q == cnt_one) begin
            state_d      = DRAIN;
            addr_valid_d = 1'b0;
          end
        end
      end
      DRAIN: begin
      end
      default: state_d = IDLE;
    endcase

    // Capture the word returned for last cycle's read.
    if (inflight_q) begin
      fifo_d[wr_ptr_q] = ram_q;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (xfer) begin
      rd_ptr_d     = ~rd_ptr_q;
      words_left_d = words_left_q - cnt_one;
      // The final transfer always happens in DRAIN, since the final read
      // was issued at least two cycles earlier.
      if (words_left_q == cnt_one) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, xfer};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      issue_left_q <= '0;
      words_left_q <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      issue_left_q <= issue_left_d;
      words_left_q <= words_left_d;
      inflight_q   <= inflight_d;
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_q[0]    <= fifo_d[0];
      fifo_q[1]    <= fifo_d[1];
      done_q       <= done_d;
    end
  end

  assign ram_addr  = addr_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = fifo_q[rd_ptr_q];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

`ifdef RAM_READER_LAST_EN
  // Exactly one word remains to be transferred when the head is the last.
  assign out_last = out_valid && (words_left_q == cnt_one);
`endif

endmodule

// File: tb/tb_ram_reader.sv
module tb_ram_reader;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   count = '0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
`ifdef RAM_READER_LAST_EN
  logic          out_last;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop = 0;

  logic [DW-1:0] exp_q[$];
  bit            exp_last_q[$];
  logic [DW-1:0] mem [0:15];

  bit ready_toggle = 1'b0;
  int tog_cyc = 0;

  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  ram_reader #(.dwidth(DW), .awidth(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .count     (count),
    .ram_addr  (ram_addr),
    .ram_q     (ram_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
`ifdef RAM_READER_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model: q follows the address presented last cycle.
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i + 1);
  end
  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", out_data, $time);
        end else begin
          logic [DW-1:0] ed;
          bit el;
          ed = exp_q.pop_front();
          el = exp_last_q.pop_front();
          check("data", 32'(out_data), 32'(ed));
`ifdef RAM_READER_LAST_EN
          check("last", 32'(out_last), 32'(el));
`endif
          n_pop++;
          $display("word %0h accepted at %0t", out_data, $time);
        end
      end
`ifdef RAM_READER_LAST_EN
      if (!out_valid && out_last) begin
        n_cmp++;
        n_bad++;
        $display("FAIL last_idle: got 1 expected 0 at %0t", $time);
      end
`endif
      if (done) check("done_drained", 32'(exp_q.size()), 32'd0);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Stall pattern driver: 1,0,0,1,0,0,...
  always @(posedge clk) begin
    #1;
    if (ready_toggle) begin
      out_ready = (tog_cyc % 3 == 0);
      tog_cyc++;
    end
  end

  task automatic push_burst(input int b, input int c);
    for (int i = 0; i < c; i++) begin
      exp_q.push_back(DW'(((b + i) % 16) + 1));
      exp_last_q.push_back(i == c - 1);
    end
  endtask

  // Returns 1 time unit after the edge that samples start.
  task automatic do_start(input int b, input int c);
    push_burst(b, c);
    @(posedge clk);
    #1;
    base  = AW'(b);
    count = (AW+1)'(c);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (t < 300) begin
      @(negedge clk);
      if (done) break;
      t++;
    end
    n_cmp++;
    if (t >= 300) begin
      n_bad++;
      $display("FAIL %s: got no done expected done within 300 cycles", name);
    end
  endtask

  initial begin
    int p0;
    int t;

    // Reset state (asynchronous).
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Burst 1: base 0, count 4, latency and done timing.
    do_start(0, 4);
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      check($sformatf("t1_valid_%0d", j), 32'(out_valid), 32'(j >= 3 && j <= 6));
      check($sformatf("t1_busy_%0d", j), 32'(busy), 32'(j <= 6));
      check($sformatf("t1_done_%0d", j), 32'(done), 32'(j == 7));
    end

    // Burst 2: address wrap.
    p0 = n_pop;
    do_start(14, 4);
    wait_done("t2_done");
    check("t2_count", 32'(n_pop - p0), 32'd4);

    // Burst 3: full depth with stalls.
    @(posedge clk);
    #1;
    tog_cyc = 0;
    ready_toggle = 1'b1;
    p0 = n_pop;
    do_start(0, 16);
    wait_done("t3_done");
    check("t3_count", 32'(n_pop - p0), 32'd16);
    ready_toggle = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Zero-length request.
    do_start(3, 0);
    for (int j = 0; j <= 2; j++) begin
      @(negedge clk);
      check($sformatf("t4_busy_%0d", j), 32'(busy), 32'd0);
      check($sformatf("t4_done_%0d", j), 32'(done), 32'(j == 0));
      check($sformatf("t4_valid_%0d", j), 32'(out_valid), 32'd0);
    end

    // Reset mid-burst.
    p0 = n_pop;
    do_start(0, 10);
    t = 0;
    while (n_pop < p0 + 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t5_two_words", 32'(n_pop - p0 >= 2), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_data", 32'(out_data), 32'd0);
    check("t5_addr", 32'(ram_addr), 32'd0);
    exp_q.delete();
    exp_last_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("t5_idle_valid_%0d", j), 32'(out_valid), 32'd0);
      check($sformatf("t5_idle_busy_%0d", j), 32'(busy), 32'd0);
    end
    p0 = n_pop;
    do_start(5, 1);
    wait_done("t5_done");
    check("t5_count", 32'(n_pop - p0), 32'd1);

`ifdef RAM_READER_LAST_EN
    // Last-word flag.
    p0 = n_pop;
    do_start(0, 3);
    wait_done("t6_done");
    check("t6_count", 32'(n_pop - p0), 32'd3);
`endif

    repeat (3) @(negedge clk);
    check("leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
